// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: ALU/MIPS encodings, decode and stage structs, forwarding helper
package alu_operand_stage_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  typedef struct packed {
    logic [3:0] ctl;
    logic       imm_sel;
    logic       zext;
    logic       dest_rt;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } dec_t;
  typedef struct packed {
    logic        valid;
    logic [3:0]  ctl;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } ex_t;
  localparam ex_t EX_BUBBLE = '{valid: 1'b0, ctl: ALU_ADD, data_1: 32'd0, data_2: 32'd0,
                                store_data: 32'd0, dest: 5'd0, reg_write: 1'b0, mem_read: 1'b0,
                                mem_write: 1'b0, branch: 1'b0, illegal: 1'b0};
  // EX/MEM wins over MEM/WB; r0 is hardwired so it is never forwarded
  function automatic logic [31:0] fwd_sel(input logic [4:0] a, input logic [31:0] rf,
                                          input logic me, input logic [4:0] ma, input logic [31:0] md,
                                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
    return (a == 5'd0) ? rf : (me && ma == a) ? md : (we && wa == a) ? wd : rf;
  endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode/forwarding inputs and EX-stage outputs of the operand stage
interface alu_operand_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_addr;
  logic [31:0] wb_fwd_data;
  logic        ex_valid;
  logic [3:0]  ex_ctl;
  logic [31:0] ex_data_1;
  logic [31:0] ex_data_2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;
  logic        load_use;
  modport slave (
    input  stall, flush, id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    output ex_valid, ex_ctl, ex_data_1, ex_data_2, ex_store_data, ex_dest, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_illegal, load_use
  );
  modport master (
    output stall, flush, id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    input  ex_valid, ex_ctl, ex_data_1, ex_data_2, ex_store_data, ex_dest, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_illegal, load_use
  );
endinterface

// File: rtl/alu_operand_stage_decode.sv
// alu_decode: opcode/funct to ALU control, immediate select, extension type and strobes
module alu_decode
  import alu_operand_stage_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);
  logic       w_r_ok;
  logic [3:0] w_r_ctl;
  assign w_r_ok  = i_funct inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_NOR};
  assign w_r_ctl = (i_funct inside {F_ADD, F_ADDU}) ? ALU_ADD :
                   (i_funct inside {F_SUB, F_SUBU}) ? ALU_SUB :
                   (i_funct == F_AND) ? ALU_AND :
                   (i_funct == F_OR)  ? ALU_OR : ALU_NOR;
  always_comb begin
    o_dec = '0;
    o_dec.ctl = ALU_ADD;
    o_dec.dest_rt = 1'b1;
    o_dec.illegal = 1'b1;
    case (i_opcode)
      OP_RTYPE: if (w_r_ok) begin
        o_dec.ctl = w_r_ctl;
        o_dec.dest_rt = 1'b0;
        o_dec.reg_write = 1'b1;
        o_dec.illegal = 1'b0;
      end
      OP_ADDI, OP_ADDIU: begin
        o_dec.imm_sel = 1'b1;
        o_dec.reg_write = 1'b1;
        o_dec.illegal = 1'b0;
      end
      OP_ANDI, OP_ORI: begin
        o_dec.ctl = (i_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        o_dec.imm_sel = 1'b1;
        o_dec.zext = 1'b1;
        o_dec.reg_write = 1'b1;
        o_dec.illegal = 1'b0;
      end
      OP_LW: begin
        o_dec.imm_sel = 1'b1;
        o_dec.reg_write = 1'b1;
        o_dec.mem_read = 1'b1;
        o_dec.illegal = 1'b0;
      end
      OP_SW: begin
        o_dec.imm_sel = 1'b1;
        o_dec.mem_write = 1'b1;
        o_dec.illegal = 1'b0;
      end
      OP_BEQ: begin
        o_dec.ctl = ALU_SUB;
        o_dec.branch = 1'b1;
        o_dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with decode, operand forwarding and load-use detection
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input logic clk,
  input logic rst_n,
  alu_operand_stage_if.slave bus
);
  dec_t        w_dec;
  ex_t         w_nxt;
  ex_t         r_ex;
  logic [31:0] w_rs;
  logic [31:0] w_rt;
  logic [31:0] w_ext;
  logic [4:0]  w_dest;
  alu_decode u_dec (.i_opcode(bus.id_opcode), .i_funct(bus.id_funct), .o_dec(w_dec));
  assign w_rs   = fwd_sel(bus.id_rs, bus.id_rs_data, bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
                          bus.wb_fwd_en, bus.wb_fwd_addr, bus.wb_fwd_data);
  assign w_rt   = fwd_sel(bus.id_rt, bus.id_rt_data, bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
                          bus.wb_fwd_en, bus.wb_fwd_addr, bus.wb_fwd_data);
  assign w_ext  = w_dec.zext ? {16'd0, bus.id_imm} : {{16{bus.id_imm[15]}}, bus.id_imm};
  assign w_dest = w_dec.dest_rt ? bus.id_rt : bus.id_rd;
  assign w_nxt  = '{valid: 1'b1, ctl: w_dec.ctl, data_1: w_rs, data_2: w_dec.imm_sel ? w_ext : w_rt,
                    store_data: w_rt, dest: w_dest, reg_write: w_dec.reg_write && w_dest != 5'd0,
                    mem_read: w_dec.mem_read, mem_write: w_dec.mem_write, branch: w_dec.branch,
                    illegal: w_dec.illegal};
  // flush beats stall, so a simultaneous stall+flush still inserts a bubble
  always_ff @(posedge clk)
    if (!rst_n || bus.flush || (!bus.stall && !bus.id_valid)) r_ex <= EX_BUBBLE;
    else if (!bus.stall) r_ex <= w_nxt;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_ctl        = r_ex.ctl;
  assign bus.ex_data_1     = r_ex.data_1;
  assign bus.ex_data_2     = r_ex.data_2;
  assign bus.ex_store_data = r_ex.store_data;
  assign bus.ex_dest       = r_ex.dest;
  assign bus.ex_reg_write  = r_ex.reg_write;
  assign bus.ex_mem_read   = r_ex.mem_read;
  assign bus.ex_mem_write  = r_ex.mem_write;
  assign bus.ex_branch     = r_ex.branch;
  assign bus.ex_illegal    = r_ex.illegal;
  assign bus.load_use = r_ex.valid && r_ex.mem_read && r_ex.dest != 5'd0 &&
                        (r_ex.dest == bus.id_rs || r_ex.dest == bus.id_rt) && bus.id_valid;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench with a behavioural reference model and random stimulus
module tb_alu_operand_stage;
  typedef struct {
    int          tgt;
    logic        valid;
    logic [3:0]  ctl;
    logic [31:0] d1, d2, sd;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, il;
    bit          c_d2, c_sd, c_dest;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t cur_m;
  alu_operand_stage_if bus();
  alu_operand_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  function automatic exp_t bubble();
    exp_t e;
    e.tgt = 0; e.valid = 0; e.ctl = 4'b0010; e.d1 = 0; e.d2 = 0; e.sd = 0; e.dest = 0;
    e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.il = 0;
    e.c_d2 = 1; e.c_sd = 1; e.c_dest = 1;
    return e;
  endfunction
  function automatic logic [31:0] fwd_ref(input logic [4:0] a, input logic [31:0] rf);
    if (a != 0 && bus.mem_fwd_en && bus.mem_fwd_addr == a) return bus.mem_fwd_data;
    if (a != 0 && bus.wb_fwd_en && bus.wb_fwd_addr == a) return bus.wb_fwd_data;
    return rf;
  endfunction
  function automatic exp_t decode_ref();
    exp_t e = bubble();
    logic [31:0] sx = 32'($signed(bus.id_imm));
    logic [31:0] zx = 32'(bus.id_imm);
    logic [31:0] b = fwd_ref(bus.id_rt, bus.id_rt_data);
    e.valid = 1; e.d1 = fwd_ref(bus.id_rs, bus.id_rs_data); e.d2 = b; e.sd = b;
    e.dest = bus.id_rt; e.c_sd = 0;
    case (bus.id_opcode)
      6'h00: begin
        e.dest = bus.id_rd; e.rw = 1;
        case (bus.id_funct)
          6'h20, 6'h21: e.ctl = 4'b0010;
          6'h22, 6'h23: e.ctl = 4'b0110;
          6'h24: e.ctl = 4'b0000;
          6'h25: e.ctl = 4'b0001;
          6'h27: e.ctl = 4'b1100;
          default: e.il = 1;
        endcase
      end
      6'h08, 6'h09: begin e.d2 = sx; e.rw = 1; end
      6'h0C: begin e.ctl = 4'b0000; e.d2 = zx; e.rw = 1; end
      6'h0D: begin e.ctl = 4'b0001; e.d2 = zx; e.rw = 1; end
      6'h23: begin e.d2 = sx; e.rw = 1; e.mr = 1; end
      6'h2B: begin e.d2 = sx; e.mw = 1; e.c_sd = 1; e.c_dest = 0; end
      6'h04: begin e.ctl = 4'b0110; e.br = 1; e.c_dest = 0; end
      default: e.il = 1;
    endcase
    if (e.il) begin
      e.ctl = 4'b0010; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0;
      e.c_d2 = 0; e.c_sd = 0; e.c_dest = 0;
    end
    if (e.dest == 0) e.rw = 0;
    return e;
  endfunction
  task automatic cycle();
    exp_t e;
    if (!rst_n || bus.flush) e = bubble();
    else if (bus.stall) e = cur_m;
    else if (!bus.id_valid) e = bubble();
    else e = decode_ref();
    e.tgt = cyc + 1;
    q.push_back(e);
    cur_m = e;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
    bus.id_valid = 1; bus.id_opcode = op; bus.id_funct = fn; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.stall = 0; bus.flush = 0; bus.mem_fwd_en = 0; bus.wb_fwd_en = 0;
  endtask
  task automatic rand_fwd();
    bus.mem_fwd_en = 1'($urandom); bus.mem_fwd_addr = 5'($urandom % 8); bus.mem_fwd_data = $urandom;
    bus.wb_fwd_en = 1'($urandom); bus.wb_fwd_addr = 5'($urandom % 8); bus.wb_fwd_data = $urandom;
  endtask
  task automatic rand_id();
    logic [5:0] ops [9] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h00};
    logic [5:0] fns [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h00};
    bus.id_valid = ($urandom % 6) != 0;
    bus.id_opcode = ($urandom % 10 == 0) ? 6'($urandom) : ops[$urandom % 9];
    bus.id_funct = ($urandom % 8 == 0) ? 6'($urandom) : fns[$urandom % 7];
    bus.id_rs = 5'($urandom % 8); bus.id_rt = 5'($urandom % 8); bus.id_rd = 5'($urandom % 8);
    bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = 16'($urandom);
    rand_fwd();
  endtask
  always begin
    exp_t e;
    logic lu;
    @(posedge clk);
    #2;
    while (q.size() > 0 && q[0].tgt == cyc) begin
      e = q.pop_front();
      chk("valid", 32'(bus.ex_valid), 32'(e.valid));
      chk("ctl", 32'(bus.ex_ctl), 32'(e.ctl));
      chk("data_1", bus.ex_data_1, e.d1);
      if (e.c_d2) chk("data_2", bus.ex_data_2, e.d2);
      if (e.c_sd) chk("store_data", bus.ex_store_data, e.sd);
      if (e.c_dest) chk("dest", 32'(bus.ex_dest), 32'(e.dest));
      chk("strobes", {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_illegal},
          {27'd0, e.rw, e.mr, e.mw, e.br, e.il});
      lu = e.valid && e.mr && e.dest != 0 && (e.dest == bus.id_rs || e.dest == bus.id_rt) && bus.id_valid;
      chk("load_use", 32'(bus.load_use), 32'(lu));
    end
  end
  initial begin
    cur_m = bubble();
    rand_id();
    bus.stall = 1'($urandom); bus.flush = 1'($urandom);
    rst_n = 0;
    cycle();
    rand_id();
    cycle();
    rst_n = 1;
    instr(6'h00, 6'h27, 5'd3, 5'd4, 5'd5, 32'h0F0F0000, 32'h00FF00FF, 16'h0);
    cycle();
    instr(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 16'h8001);
    cycle();
    instr(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 16'h8001);
    cycle();
    instr(6'h00, 6'h20, 5'd7, 5'd6, 5'd8, 32'h1234, 32'h5678, 16'h0);
    bus.mem_fwd_en = 1; bus.mem_fwd_addr = 7; bus.mem_fwd_data = 32'hAAAA;
    bus.wb_fwd_en = 1; bus.wb_fwd_addr = 7; bus.wb_fwd_data = 32'hBBBB;
    cycle();
    instr(6'h00, 6'h20, 5'd0, 5'd6, 5'd8, 32'h1234, 32'h5678, 16'h0);
    bus.mem_fwd_en = 1; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 32'hAAAA;
    bus.wb_fwd_en = 1; bus.wb_fwd_addr = 0; bus.wb_fwd_data = 32'hBBBB;
    cycle();
    instr(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 16'h0004);
    cycle();
    instr(6'h00, 6'h20, 5'd9, 5'd2, 5'd10, 32'h3, 32'h4, 16'h0);
    bus.stall = 1; bus.flush = 1;
    cycle();
    bus.stall = 0; bus.flush = 0;
    cycle();
    instr(6'h00, 6'h20, 5'd2, 5'd3, 5'd4, 32'hCAFE0000, 32'h0000BEEF, 16'h0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1;
      rand_fwd();
      bus.id_rs_data = $urandom;
      cycle();
    end
    bus.stall = 1; rst_n = 0;
    cycle();
    rst_n = 1;
    instr(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
    cycle();
    instr(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 32'h1000, 32'h77, 16'hFFF0);
    cycle();
    instr(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'h5, 32'h5, 16'h0);
    cycle();
    for (int i = 0; i < 500; i++) begin
      rand_id();
      rst_n = ($urandom % 50) != 0;
      bus.flush = ($urandom % 20) == 0;
      bus.stall = ($urandom % 6) == 0;
      cycle();
    end
    bus.id_valid = 0; bus.stall = 0; bus.flush = 0;
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
